// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITERS = 32;
  localparam logic [4:0] ITER_LAST = 5'(ITERS - 1);
  localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring-divide step
// on a shared {hi, lo} accumulator.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_top;
  logic [XLEN:0] diff;

  // Multiply: lo holds the remaining multiplier bits, consumed LSB first.
  // Divide: hi holds the partial remainder, lo shifts dividend out and
  // quotient bits in. Since rem < divisor, diff fits a 33-bit signed range.
  always_comb begin
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem_top = acc_i[2*XLEN-1:XLEN-1];
    diff    = rem_top - {1'b0, operand_i};
    if (!is_div_i) begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
    end else begin
      acc_o = {rem_top[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit, fixed 32-iteration latency.
// MULDIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero multiplies finish in one cycle.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wren_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a request is taken on any edge where valid_i && ready_o;
  // ready_o stays low until the edge after the single-cycle done_o pulse.

  state_e              state;
  logic [4:0]          count;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   step_acc;
  logic [XLEN-1:0]     opnd;
  funct3_e             op_q;
  logic                neg_main_q;
  logic                neg_rem_q;
  logic                special_q;
  logic [XLEN-1:0]     special_val_q;

  logic                signed1, signed2, neg1, neg2, is_div_in;
  logic                div_zero, div_ovf, mul_zero, fast_special;
  logic [XLEN-1:0]     mag1, mag2, special_val;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, final_val;

  assign ready_o     = (state == ST_IDLE) & ~rst_i;
  assign rd_wren_o   = done_o;
  assign dbg_state_o = state;

  always_comb begin
    signed1 = 1'b0;
    signed2 = 1'b0;
    case (funct3_e'(funct3_i))
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        signed1 = 1'b1;
        signed2 = 1'b1;
      end
      F3_MULHSU: signed1 = 1'b1;
      default: ;
    endcase
    neg1      = signed1 & rs1_data_i[XLEN-1];
    neg2      = signed2 & rs2_data_i[XLEN-1];
    mag1      = neg1 ? -rs1_data_i : rs1_data_i;
    mag2      = neg2 ? -rs2_data_i : rs2_data_i;
    is_div_in = funct3_i[2];
    div_zero  = is_div_in & (rs2_data_i == '0);
    div_ovf   = is_div_in & signed1 & (rs1_data_i == INT_MIN) & (rs2_data_i == '1);
    mul_zero  = ~is_div_in & ((rs1_data_i == '0) | (rs2_data_i == '0));
    special_val = '0;
    if (div_zero) special_val = funct3_i[1] ? rs1_data_i : DIV_ZERO_Q;
    else if (div_ovf) special_val = funct3_i[1] ? '0 : INT_MIN;
  end

`ifdef MULDIV_FAST_SPECIAL_EN
  assign fast_special = div_zero | div_ovf | mul_zero;
`else
  assign fast_special = 1'b0;
`endif

  muldiv_step u_step (
    .is_div_i  (op_q[2]),
    .acc_i     (acc),
    .operand_i (opnd),
    .acc_o     (step_acc)
  );

  // Sign fix-up applied to the last iteration's output.
  always_comb begin
    prod = neg_main_q ? -step_acc : step_acc;
    quo  = neg_main_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem  = neg_rem_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                       final_val = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_val = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_val = quo;
      default:                      final_val = rem;
    endcase
    if (special_q) final_val = special_val_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      count         <= '0;
      done_o        <= 1'b0;
      result_o      <= '0;
      rd_addr_o     <= '0;
      acc           <= '0;
      opnd          <= '0;
      op_q          <= F3_MUL;
      neg_main_q    <= 1'b0;
      neg_rem_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_i && ready_o) begin
            op_q          <= funct3_e'(funct3_i);
            rd_addr_o     <= rd_addr_i;
            acc           <= {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
            opnd          <= is_div_in ? mag2 : mag1;
            neg_main_q    <= neg1 ^ neg2;
            neg_rem_q     <= neg1;
            special_q     <= div_zero | div_ovf | mul_zero;
            special_val_q <= special_val;
            if (fast_special) begin
              state    <= ST_DONE;
              count    <= '0;
              done_o   <= 1'b1;
              result_o <= special_val;
            end else begin
              state <= ST_CALC;
              count <= ITER_LAST;
            end
          end
        end
        ST_CALC: begin
          acc <= step_acc;
          if (count == '0) begin
            state    <= ST_DONE;
            done_o   <= 1'b1;
            result_o <= final_val;
          end else begin
            count <= count - 5'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: directed RV32M cases, special cases,
// reset abort, busy-time requests and randomized ops against an arithmetic model.
module tb_muldiv_iter;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [4:0]  rd_addr_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wren_o;
  logic [1:0]  dbg_state_o;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];

  muldiv_iter dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .rd_wren_o  (rd_wren_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: plain 64-bit product and SV integer division
  function automatic logic [31:0] ref_result(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    logic ovf;
    ea  = (f3 <= 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    eb  = (f3 <= 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p   = ea * eb;
    sa  = signed'(a);
    sb  = signed'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    logic special;
    special = f3[2] ? ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                    : ((a == 0) || (b == 0));
`ifdef MULDIV_FAST_SPECIAL_EN
    return special ? 1 : 32;
`else
    return special ? 32 : 32;
`endif
  endfunction

  // driver: called #1 after a posedge; issues one op and waits for done_o
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] addr,
                        output int lat, output logic wren);
    int guard;
    guard = 0;
    while (!ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    valid_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0; res = '0; addr = '0; wren = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = i; res = result_o; addr = rd_addr_o; wren = rd_wren_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ready_o, done_o, rd_wren_o, result_o, rd_addr_o} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ready=%b done=%b wren=%b res=%h rd=%0d, want all 0",
               ready_o, done_o, rd_wren_o, result_o, rd_addr_o);
    end
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", ready_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [2:0]  f3s [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0};
    logic [31:0] as  [14] = '{32'd7, '1, '1, '1, '1, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0};
    logic [31:0] bs  [14] = '{32'hFFFF_FFFD, '1, '1, '1, '1, 32'd2, 32'd2, 32'd2, 32'd2,
                              32'd0, 32'd0, '1, '1, 32'd1234};
    logic [31:0] exs [14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFD,
                              32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                              32'h0, 32'h0};
    logic [31:0] res;
    logic [4:0]  addr;
    logic        wren;
    int          lat, exp_lat;
    for (int i = 0; i < 14; i++) begin
      run_op(f3s[i], as[i], bs[i], 5'd5, res, addr, lat, wren);
`ifdef MULDIV_FAST_SPECIAL_EN
      exp_lat = (i >= 9) ? 1 : 32;
`else
      exp_lat = 32;
`endif
      tests_run++;
      if (res !== exs[i] || lat != exp_lat || addr !== 5'd5 || wren !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed_%0d: got res=%h lat=%0d rd=%0d wren=%b, want res=%h lat=%0d rd=5 wren=1",
                 i, res, lat, addr, wren, exs[i], exp_lat);
      end
      @(posedge clk); #1;
      tests_run++;
      if (done_o !== 1'b0 || ready_o !== 1'b1 || result_o !== exs[i]) begin
        tests_failed++;
        $display("FAIL directed_pulse_%0d: got done=%b ready=%b res=%h, want done=0 ready=1 res=%h",
                 i, done_o, ready_o, result_o, exs[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [31:0] res;
    logic [4:0]  addr;
    logic        wren;
    int          lat;
    valid_i = 1'b1; funct3_i = 3'd4; rs1_data_i = 32'hFFFF_FFF9; rs2_data_i = 32'd2; rd_addr_i = 5'd17;
    @(posedge clk); #1;
    valid_i = 1'b0;
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({ready_o, done_o, rd_wren_o, result_o, rd_addr_o} !== 40'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got ready=%b done=%b wren=%b res=%h rd=%0d, want all 0",
               ready_o, done_o, rd_wren_o, result_o, rd_addr_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    #1;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_ready: got %b want 1", ready_o);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o || rd_wren_o) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: got %0d done pulses, want 0", dones);
    end
    run_op(3'd0, 32'd3, 32'd4, 5'd2, res, addr, lat, wren);
    tests_run++;
    if (res !== 32'h0000_000C || addr !== 5'd2 || lat != 32) begin
      tests_failed++;
      $display("FAIL reset_mid_followup: got res=%h rd=%0d lat=%0d, want res=0000000c rd=2 lat=32", res, addr, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int dones, busy_ready, lat;
    logic [31:0] res;
    logic [4:0]  addr;
    valid_i = 1'b1; funct3_i = 3'd5; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd9;
    @(posedge clk); #1;
    dones = 0; busy_ready = 0; lat = 0; res = '0; addr = '0;
    for (int i = 1; i <= 40; i++) begin
      funct3_i = 3'($urandom_range(0, 7)); rs1_data_i = $urandom; rs2_data_i = $urandom;
      rd_addr_i = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      if (ready_o) busy_ready++;
      if (done_o) begin
        dones++; lat = i; res = result_o; addr = rd_addr_o;
        break;
      end
    end
    tests_run++;
    if (dones != 1 || lat != 32 || res !== 32'h0000_000E || addr !== 5'd9 || busy_ready != 0) begin
      tests_failed++;
      $display("FAIL busy_first: got dones=%0d lat=%0d res=%h rd=%0d busy_ready=%0d, want 1 32 0000000e 9 0",
               dones, lat, res, addr, busy_ready);
    end
    funct3_i = 3'd0; rs1_data_i = 32'd6; rs2_data_i = 32'd7; rd_addr_i = 5'd3;
    @(posedge clk); #1;
    tests_run++;
    if (ready_o !== 1'b1 || done_o !== 1'b0 || rd_addr_o !== 5'd9) begin
      tests_failed++;
      $display("FAIL busy_reissue: got ready=%b done=%b rd=%0d, want ready=1 done=0 rd=9", ready_o, done_o, rd_addr_o);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_o) begin
        lat = i; res = result_o; addr = rd_addr_o;
        break;
      end
    end
    tests_run++;
    if (lat != 32 || res !== 32'd42 || addr !== 5'd3) begin
      tests_failed++;
      $display("FAIL busy_second: got lat=%0d res=%h rd=%0d, want lat=32 res=0000002a rd=3", lat, res, addr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, res, exp_res;
    logic [4:0]  rd, addr;
    logic        wren;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'd0;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      rd = 5'($urandom_range(0, 31));
      exp_q.push_back(ref_result(f3, a, b));
      run_op(f3, a, b, rd, res, addr, lat, wren);
      exp_res = exp_q.pop_front();
      tests_run++;
      if (res !== exp_res || addr !== rd || wren !== 1'b1 || lat != ref_latency(f3, a, b)) begin
        tests_failed++;
        $display("FAIL random_%0d f3=%0d a=%h b=%h: got res=%h rd=%0d wren=%b lat=%0d, want res=%h rd=%0d wren=1 lat=%0d",
                 n, f3, a, b, res, addr, wren, lat, exp_res, rd, ref_latency(f3, a, b));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
